// File: rtl/xoodoo_pkg.sv
// rtl/xoodoo_pkg.sv - shared Xoodoo state/lane types, round constants, lane indexing and FSM encoding
package xoodoo_pkg;

    typedef logic [383:0] state_t;
    typedef logic [31:0]  lane_t;

    localparam int NLANES = 12;

    // Round constants in application order; a reduced permutation uses the tail of this table.
    localparam lane_t RC_TABLE [0:11] = '{
        32'h0000_0058, 32'h0000_0038, 32'h0000_03C0, 32'h0000_00D0,
        32'h0000_0120, 32'h0000_0014, 32'h0000_0060, 32'h0000_002C,
        32'h0000_0380, 32'h0000_00F0, 32'h0000_01A0, 32'h0000_0012
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_state_e;

    // Lane number of column x in plane y; callers pass non-negative offsets (x+3 for x-1).
    function automatic int lane_idx(input int x, input int y);
        return 4 * (y % 3) + (x % 4);
    endfunction

    // Out-of-range indices yield zero so idle-time lookups never read past the table.
    function automatic lane_t rc_at(input logic [3:0] idx);
        rc_at = '0;
        if (idx < 4'd12) begin
            rc_at = RC_TABLE[idx];
        end
    endfunction

endpackage

// File: rtl/xoodoo_if.sv
// rtl/xoodoo_if.sv - request/response bundle between the sponge controller and the permutation
interface xoodoo_if;

    logic                  start;
    xoodoo_pkg::state_t    state_in;
    xoodoo_pkg::state_t    state_out;
    logic                  done;
    logic                  busy;

    modport master (
        output start,
        output state_in,
        input  state_out,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  state_in,
        output state_out,
        output done,
        output busy
    );

endinterface

// File: rtl/xoodoo_round.sv
// rtl/xoodoo_round.sv - one combinational Xoodoo round: theta, rho-west, iota, chi, rho-east
module xoodoo_round
    import xoodoo_pkg::*;
(
    input  state_t state_in,
    input  lane_t  rc,
    output state_t state_out
);

    function automatic lane_t rotl(input lane_t v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    lane_t a [NLANES];
    lane_t t [NLANES];
    lane_t w [NLANES];
    lane_t c [NLANES];
    lane_t p [4];
    lane_t e [4];

    // Column parity and the theta effect, which mixes the parity of the previous column.
    for (genvar x = 0; x < 4; x++) begin : g_col
        assign p[x] = a[lane_idx(x, 0)] ^ a[lane_idx(x, 1)] ^ a[lane_idx(x, 2)];
        assign e[x] = rotl(p[(x + 3) % 4], 5) ^ rotl(p[(x + 3) % 4], 14);
    end

    for (genvar y = 0; y < 3; y++) begin : g_row
        for (genvar x = 0; x < 4; x++) begin : g_lane
            localparam int L = lane_idx(x, y);

            assign a[L] = state_in[32*L +: 32];
            assign t[L] = a[L] ^ e[x];

            if (y == 0) begin : g_p0
                if (x == 0) begin : g_iota
                    assign w[L] = t[L] ^ rc;
                end else begin : g_pass
                    assign w[L] = t[L];
                end
                assign state_out[32*L +: 32] = c[L];
            end else if (y == 1) begin : g_p1
                assign w[L] = t[lane_idx(x + 3, 1)];
                assign state_out[32*L +: 32] = rotl(c[L], 1);
            end else begin : g_p2
                assign w[L] = rotl(t[L], 11);
                assign state_out[32*L +: 32] = rotl(c[lane_idx(x + 2, 2)], 8);
            end

            // chi reads only rho-west outputs, so every plane sees pre-chi neighbours.
            assign c[L] = w[L] ^ (~w[lane_idx(x, y + 1)] & w[lane_idx(x, y + 2)]);
        end
    end

endmodule

// File: rtl/xoodoo_perm.sv
// rtl/xoodoo_perm.sv - iterative Xoodoo[NROUNDS] permutation; XOODOO_UNROLL2_EN chains two rounds per cycle
module xoodoo_perm
    import xoodoo_pkg::*;
#(
    parameter int NROUNDS = 12
)
(
    input  logic   clk,
    input  logic   resetn,
    xoodoo_if.slave bus
);

`ifdef XOODOO_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam logic [3:0] RC_BASE  = 4'(12 - NROUNDS);
    localparam logic [3:0] LAST_CNT = 4'(NROUNDS - STEP);
    localparam logic [3:0] CNT_STEP = 4'(STEP);

    perm_state_e state_q;
    perm_state_e state_d;
    logic [3:0]  cnt_q;
    state_t      st_q;
    state_t      out_q;
    logic        done_q;
    state_t      round_res;
    logic [3:0]  rc_idx;
    lane_t       rc0;
    logic        last_round;

    assign rc_idx     = RC_BASE + cnt_q;
    assign rc0        = rc_at(rc_idx);
    assign last_round = (cnt_q == LAST_CNT);

`ifdef XOODOO_UNROLL2_EN
    state_t mid_res;
    lane_t  rc1;

    assign rc1 = rc_at(rc_idx + 4'd1);

    xoodoo_round u_round0 (
        .state_in  (st_q),
        .rc        (rc0),
        .state_out (mid_res)
    );

    xoodoo_round u_round1 (
        .state_in  (mid_res),
        .rc        (rc1),
        .state_out (round_res)
    );
`else
    xoodoo_round u_round (
        .state_in  (st_q),
        .rc        (rc0),
        .state_out (round_res)
    );
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start is only honoured from IDLE, DONE always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_round) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accepted start, one (or two) rounds per RUN cycle, publish on the last.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            st_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        st_q  <= bus.state_in;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    st_q <= round_res;
                    if (last_round) begin
                        out_q  <= round_res;
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state_out = out_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_xoodoo_perm.sv
// tb/tb_xoodoo_perm.sv - randomized self-checking bench against a plane/column Xoodoo model
module tb_xoodoo_perm;

`ifdef XOODOO_UNROLL2_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 12;
`endif

    localparam logic [31:0] RC_REF [12] = '{
        32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
    };

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    xoodoo_if bus();
    xoodoo_perm #(.NROUNDS(12)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifndef XOODOO_UNROLL2_EN
    xoodoo_if bus1();
    xoodoo_perm #(.NROUNDS(1)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );
`endif

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference permutation on a 3x4 plane/column array, rounds 12-nr .. 11.
    function automatic logic [383:0] ref_perm(input logic [383:0] s, input int nr);
        logic [31:0] a [3][4];
        logic [31:0] b [3][4];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [383:0] r;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = s[32*(4*y+x) +: 32];
        for (int rnd = 12 - nr; rnd < 12; rnd++) begin
            for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
            for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
            for (int x = 0; x < 4; x++) begin
                b[0][x] = a[0][x];
                b[1][x] = a[1][(x+3)%4];
                b[2][x] = rotl(a[2][x], 11);
            end
            b[0][0] = b[0][0] ^ RC_REF[rnd];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++)
                    a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
            for (int x = 0; x < 4; x++) begin
                b[0][x] = a[0][x];
                b[1][x] = rotl(a[1][x], 1);
                b[2][x] = rotl(a[2][(x+2)%4], 8);
            end
            a = b;
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                r[32*(4*y+x) +: 32] = a[y][x];
        return r;
    endfunction

    function automatic logic [383:0] rand_state();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Pulse start for one cycle, then wait (bounded) for done; lat stays -1 on timeout.
    task automatic run_perm(input logic [383:0] s, output int lat, output logic [383:0] res,
                            output bit stable);
        logic [383:0] prev;
        prev = bus.state_out;
        stable = 1'b1;
        lat = -1;
        bus.state_in = s;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.state_out !== prev || bus.busy !== 1'b1) stable = 1'b0;
        end
        res = bus.state_out;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.state_in = '0;
`ifndef XOODOO_UNROLL2_EN
        bus1.start = 1'b0;
        bus1.state_in = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.state_out !== '0) begin n_errors++; $display("FAIL reset_state_out got %h want 0", bus.state_out); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        resetn = 1'b1;
    endtask

    task automatic test_zero();
        int lat; logic [383:0] res; bit stable; logic [383:0] exp;
        exp = ref_perm('0, 12);
        run_perm('0, lat, res, stable);
        n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL zero_latency got %0d want %0d", lat, LAT); end
        n_checks++; if (res !== exp) begin n_errors++; $display("FAIL zero_result got %h want %h", res, exp); end
        n_checks++; if (!stable) begin n_errors++; $display("FAIL zero_run_stable got 0 want 1"); end
        @(posedge clk); #1;
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL zero_done_width got %b want 0", bus.done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [383:0] res; bit stable; logic [383:0] s;
        for (int k = 0; k < 5; k++) begin
            s = rand_state();
            run_perm(s, lat, res, stable);
            n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL b2b%0d_latency got %0d want %0d", k, lat, LAT); end
            n_checks++; if (res !== ref_perm(s, 12)) begin n_errors++; $display("FAIL b2b%0d_result got %h want %h", k, res, ref_perm(s, 12)); end
            n_checks++; if (!stable) begin n_errors++; $display("FAIL b2b%0d_run_stable got 0 want 1", k); end
            @(posedge clk); #1;
            n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL b2b%0d_done_width got %b want 0", k, bus.done); end
        end
    endtask

    task automatic test_restart_ignored();
        logic [383:0] s; logic [383:0] s2; logic [383:0] res;
        int ndone; int first;
        s = rand_state();
        s2 = rand_state();
        res = '0;
        ndone = 0;
        first = -1;
        bus.state_in = s;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.state_in = s2;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (first < 0) first = c;
                res = bus.state_out;
            end
            bus.start = (c == 3 || c == LAT - 1);
        end
        bus.start = 1'b0;
        n_checks++; if (first !== LAT) begin n_errors++; $display("FAIL restart_latency got %0d want %0d", first, LAT); end
        n_checks++; if (ndone !== 1) begin n_errors++; $display("FAIL restart_done_count got %0d want 1", ndone); end
        n_checks++; if (res !== ref_perm(s, 12)) begin n_errors++; $display("FAIL restart_result got %h want %h", res, ref_perm(s, 12)); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL restart_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_start_on_done();
        int lat; logic [383:0] res; bit stable; logic [383:0] s; bit quiet;
        s = rand_state();
        run_perm(s, lat, res, stable);
        bus.state_in = rand_state();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++; if (!quiet) begin n_errors++; $display("FAIL start_on_done_ignored got busy/done activity want none"); end
        n_checks++; if (bus.state_out !== ref_perm(s, 12)) begin n_errors++; $display("FAIL start_on_done_hold got %h want %h", bus.state_out, ref_perm(s, 12)); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [383:0] res; bit stable; logic [383:0] s; bit no_done;
        s = rand_state();
        no_done = 1'b1;
        bus.state_in = s;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (bus.done) no_done = 1'b0;
        end
        resetn = 1'b0;
        #1;
        n_checks++; if (bus.state_out !== '0) begin n_errors++; $display("FAIL midreset_state_out got %h want 0", bus.state_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) no_done = 1'b0;
        end
        resetn = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++; if (!no_done) begin n_errors++; $display("FAIL midreset_no_done got activity want none"); end
        s = rand_state();
        run_perm(s, lat, res, stable);
        n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL midreset_fresh_latency got %0d want %0d", lat, LAT); end
        n_checks++; if (res !== ref_perm(s, 12)) begin n_errors++; $display("FAIL midreset_fresh_result got %h want %h", res, ref_perm(s, 12)); end
        @(posedge clk); #1;
    endtask

`ifndef XOODOO_UNROLL2_EN
    task automatic test_one_round();
        logic [383:0] s; int lat;
        s = '1;
        lat = -1;
        bus1.state_in = s;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus1.done) begin
                lat = c;
                break;
            end
        end
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL one_round_latency got %0d want 1", lat); end
        n_checks++; if (bus1.state_out !== ref_perm(s, 1)) begin n_errors++; $display("FAIL one_round_result got %h want %h", bus1.state_out, ref_perm(s, 1)); end
        @(posedge clk); #1;
        n_checks++; if (bus1.done !== 1'b0) begin n_errors++; $display("FAIL one_round_done_width got %b want 0", bus1.done); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_restart_ignored();
        test_start_on_done();
        test_reset_mid_run();
`ifndef XOODOO_UNROLL2_EN
        test_one_round();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xoodoo_perm.md
XOODOO_PERM -- requirements
Module: xoodoo_perm

Interface
REQ-001 The block SHALL have parameter NROUNDS, default 12, giving the number of Xoodoo rounds per permutation; legal values are 1..12, and it uses the last NROUNDS round constants.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request from the sponge controller (its xoodoo_enable).
REQ-005 The block SHALL have port state_in, input, 384 bits: the state to permute; lane i=4*y+x occupies bits [32i+31:32i], little-endian, so byte 0 is bits [7:0].
REQ-006 The block SHALL have port state_out, output, 384 bits: the permuted state, with the same lane mapping.
REQ-007 The block SHALL have port done, output, 1 bit: a one-cycle completion strobe (the controller's xoodoo_complete).
REQ-008 The block SHALL have port busy, output, 1 bit: high while a permutation is in progress.

Function
REQ-009 The FSM SHALL have states IDLE, RUN and DONE.
  - IDLE->RUN on start.
  - RUN->DONE after the final round.
  - DONE->IDLE unconditionally.
REQ-010 On start in IDLE, the block SHALL capture state_in into the internal state register and clear the round counter (4 bits) to 0.
REQ-011 In RUN, each clock SHALL apply one round with constant RC[12-NROUNDS+cnt], then increment cnt.
REQ-012 Each round SHALL be, in order:
  - theta: P=A0^A1^A2; E[x]=rotl(P[x-1],5)^rotl(P[x-1],14); every A[y][x]^=E[x].
  - rho-west: A1[x]=A1[x-1]; A2[x]=rotl(A2[x],11).
  - iota: A0[0]^=RC.
  - chi: Ay^=~A(y+1)&A(y+2), planes taken mod 3, all computed from pre-chi values.
  - rho-east: A1[x]=rotl(A1[x],1); A2[x]=rotl(A2[x+2],8).
  - Lane indices x are taken mod 4.
REQ-013 RC[0..11] SHALL be 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014, 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012, zero-extended to 32 bits.
REQ-014 Latency: with start sampled at edge E0, the final round SHALL register at edge E(NROUNDS), and state_out and done SHALL update at that same edge; at default, done is high in the 12th cycle after start, within the controller's 23-cycle window.
REQ-015 done SHALL be high for exactly one cycle per permutation.
REQ-016 state_out SHALL hold its value until the next completion and SHALL NOT change during RUN.
REQ-017 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-018 start while busy is high SHALL be ignored, with no queueing and no restart.
REQ-019 start asserted in the same cycle done is high SHALL be ignored; a new permutation is accepted from IDLE only.
REQ-020 The round counter SHALL never wrap; it reaches NROUNDS-1 in its last RUN cycle.
REQ-021 A new start SHALL overwrite the internal state only, never state_out.

Reset
REQ-022 Asserting resetn low SHALL immediately force the FSM to IDLE, cnt to 0, the internal state to 0, state_out to 0, done to 0 and busy to 0.
REQ-023 Reset asserted mid-RUN SHALL abort the permutation with no done pulse; after release, the block SHALL accept start on the first clock edge.

Configuration
REQ-024 The macro XOODOO_UNROLL2_EN SHALL control round unrolling.
  - Defined: two chained rounds per RUN cycle, latency NROUNDS/2 cycles (6 at default); NROUNDS must be even.
  - Undefined: one round per cycle as in REQ-011..014.
  - All interface behaviour other than latency is identical in both builds.

Structure
REQ-025 A shared package xoodoo_pkg SHALL hold:
  - the 384-bit state typedef;
  - the lane typedef (32 bits);
  - the RC table constant;
  - a lane-index helper function;
  - FSM state encodings.
  It is shared with the sponge controller.
REQ-026 The round function SHALL be a purely combinational sub-module xoodoo_round (state, rc in; state out), instantiated once, or twice under XOODOO_UNROLL2_EN.

Verification
REQ-027 All-zero state_in with one start pulse SHALL produce done exactly 12 cycles later, and state_out SHALL equal the golden software Xoodoo[12] output bit-exactly.
REQ-028 Five back-to-back permutations of random states, each started the cycle after the previous done, SHALL all match the golden model with no lost pulses.
REQ-029 start re-pulsed at cycles 3 and 11 of a run SHALL produce no change to latency or result and exactly one done.
REQ-030 resetn low at cycle 6 of a run SHALL produce: state_out=0, busy=0, no done; a fresh start then gives a correct result.
REQ-031 state_in=0xFF..FF with NROUNDS=1 SHALL produce done after 1 cycle, and the result SHALL equal one round with RC=0x012.
REQ-032 The XOODOO_UNROLL2_EN build SHALL produce done after 6 cycles with a result identical to the default build for the same inputs.
